// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared debounce FSM state encoding and default stability window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    localparam int unsigned c_stable_cycles_default = 500000;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Generic 1-bit two-flop synchronizer with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Pushbutton debouncer with level, press/release pulses, sticky
//               pending flag; optional press counter under BTN_PRESS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = c_stable_cycles_default,
    parameter int unsigned CNT_WIDTH     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       pending_clr,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       press_pending
`ifdef BTN_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 w_sync;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_accept_press;
    logic                 w_accept_release;

    sync_2ff u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (btn_in),
        .o_q (w_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter only advances below c_cnt_last, so it can never wrap.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (w_sync) begin
                    w_state_nxt = CHECK_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt    = IDLE_HIGH;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = CHECK_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            CHECK_LOW: begin
                if (w_sync) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt      = IDLE_LOW;
                    w_cnt_nxt        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Set also holds through the btn_press cycle so a coincident clear loses.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level     <= 1'b0;
            btn_press     <= 1'b0;
            btn_release   <= 1'b0;
            press_pending <= 1'b0;
        end else begin
            btn_level     <= (w_state_nxt == IDLE_HIGH) || (w_state_nxt == CHECK_LOW);
            btn_press     <= w_accept_press;
            btn_release   <= w_accept_release;
            if (w_accept_press || btn_press) begin
                press_pending <= 1'b1;
            end else if (pending_clr) begin
                press_pending <= 1'b0;
            end
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] r_press_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_count <= 8'd0;
        end else if (w_accept_press) begin
            r_press_count <= r_press_count + 8'd1;
        end
    end

    assign press_count = r_press_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// Module      : tb_btn_debounce
// Description : Self-checking bench for btn_debounce with STABLE_CYCLES=4;
//               exercises BTN_PRESS_COUNT_EN content when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

    localparam int c_stable = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_in = 1'b0;
    logic       pending_clr = 1'b0;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       press_pending;
`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    int checks = 0;
    int errors = 0;
    int press_seen = 0;

    btn_debounce #(
        .STABLE_CYCLES (c_stable),
        .CNT_WIDTH     (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .pending_clr   (pending_clr),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .press_pending (press_pending)
`ifdef BTN_PRESS_COUNT_EN
        ,
        .press_count   (press_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: level flips once the synced input has disagreed with it for
    // STABLE+1 consecutive observations; the synced input lags btn_in by two edges.
    bit       m_s1, m_s2, m_lvl, m_p, m_r, m_pend, m_prev_p;
    int       m_run;
    bit [7:0] m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_p = 0; m_r = 0;
            m_pend = 0; m_run = 0; m_cnt = 0;
        end else begin
            m_prev_p = m_p;
            m_p = 0;
            m_r = 0;
            if (m_s2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == c_stable + 1) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    m_p = m_lvl;
                    m_r = !m_lvl;
                end
            end else begin
                m_run = 0;
            end
            if (m_p || m_prev_p) m_pend = 1;
            else if (pending_clr) m_pend = 0;
            if (m_p) m_cnt = m_cnt + 8'd1;
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        #1;
        if (btn_press) press_seen++;
        checks++;
        if ({btn_level, btn_press, btn_release, press_pending} !==
            {m_lvl, m_p, m_r, m_pend}) begin
            errors++;
            $display("FAIL model_cmp t=%0t got lvl/prs/rel/pend=%b%b%b%b expected %b%b%b%b",
                     $time, btn_level, btn_press, btn_release, press_pending,
                     m_lvl, m_p, m_r, m_pend);
        end
`ifdef BTN_PRESS_COUNT_EN
        checks++;
        if (press_count !== m_cnt) begin
            errors++;
            $display("FAIL model_count t=%0t got %0d expected %0d", $time, press_count, m_cnt);
        end
`endif
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Ticks until btn_press is seen, bounded; returns the edge count or -1.
    task automatic edges_to_press(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (btn_press) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int seen0;

    initial begin
        tick(3);
        chk("reset_level", btn_level, 0);
        chk("reset_press", btn_press, 0);
        chk("reset_release", btn_release, 0);
        chk("reset_pending", press_pending, 0);
        reset = 1'b0;
        tick(2);

        // Clean press
        btn_in = 1'b1;
        tick(6);
        chk("press_level_e6", btn_level, 0);
        tick(1);
        chk("press_level_e7", btn_level, 1);
        chk("press_pulse_e7", btn_press, 1);
        chk("press_pending_e7", press_pending, 1);
        tick(1);
        chk("press_pulse_e8", btn_press, 0);

        // Release
        btn_in = 1'b0;
        tick(7);
        chk("release_level", btn_level, 0);
        chk("release_pulse", btn_release, 1);
        chk("release_pending_kept", press_pending, 1);
        tick(1);
        chk("release_pulse_end", btn_release, 0);
        pending_clr = 1'b1;
        tick(1);
        pending_clr = 1'b0;
        chk("pending_cleared", press_pending, 0);

        // Glitch rejection
        seen0 = press_seen;
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        tick(20);
        chk("glitch_level", btn_level, 0);
        chk("glitch_no_press", press_seen - seen0, 0);

        // Bounce 1,0,1,1,0 then steady 1
        seen0 = press_seen;
        btn_in = 1'b1; tick(1);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1;
        edges_to_press(n);
        chk("bounce_latency", n, 7);
        tick(10);
        chk("bounce_one_press", press_seen - seen0, 1);

        // Set/clear collision
        pending_clr = 1'b1;
        btn_in = 1'b0;
        tick(12);
        pending_clr = 1'b0;
        chk("coll_pre_pending", press_pending, 0);
        btn_in = 1'b1;
        tick(7);
        chk("coll_press", btn_press, 1);
        pending_clr = 1'b1;
        tick(1);
        chk("coll_set_wins", press_pending, 1);
        tick(1);
        pending_clr = 1'b0;
        chk("coll_clear_next", press_pending, 0);

        // Reset during CHECK_HIGH with the button held
        btn_in = 1'b0;
        tick(12);
        seen0 = press_seen;
        btn_in = 1'b1;
        tick(4);
        reset = 1'b1;
        pending_clr = 1'b1;
        tick(1);
        chk("rst_mid_level", btn_level, 0);
        chk("rst_mid_press", btn_press, 0);
        tick(1);
        pending_clr = 1'b0;
        reset = 1'b0;
        edges_to_press(n);
        chk("rst_mid_no_early_press", press_seen - seen0, 1);
        chk("rst_reaccept_latency", n, 7);

`ifdef BTN_PRESS_COUNT_EN
        chk("count_after_reaccept", press_count, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        btn_in = 1'b0;
        tick(2);
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            tick(8);
            btn_in = 1'b0;
            tick(8);
            if (i == 0) chk("count_first", press_count, 1);
        end
        chk("count_wrap", press_count, 0);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 500000, giving the consecutive synced cycles required to accept a change (5 ms at 100 MHz); legal range 2..2^CNT_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 20, giving the debounce counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn_in, input, 1 bit: raw, asynchronous pushbutton (BTNU pad).
REQ-006 SHALL have port btn_level, output, 1 bit: debounced level; drives the MMIO BTNU read at address 1000.
REQ-007 SHALL have port btn_press, output, 1 bit: one-cycle pulse when a press is accepted.
REQ-008 SHALL have port btn_release, output, 1 bit: one-cycle pulse when a release is accepted.
REQ-009 SHALL have port press_pending, output, 1 bit: sticky flag, set on an accepted press.
REQ-010 SHALL have port pending_clr, input, 1 bit: clears press_pending (asserted by software-read logic).
REQ-011 SHALL have port press_count, output, 8 bits: accepted-press counter; present only with BTN_PRESS_COUNT_EN.

Function
REQ-012 SHALL pass btn_in through a 2-flop synchronizer (sync1, sync2); the FSM observes only sync2.
REQ-013 SHALL implement FSM states IDLE_LOW, CHECK_HIGH, IDLE_HIGH and CHECK_LOW.
REQ-014 SHALL, in IDLE_LOW with sync2=1, go to CHECK_HIGH with cnt=0; in IDLE_HIGH with sync2=0, go to CHECK_LOW with cnt=0.
REQ-015 SHALL, in CHECK_HIGH (CHECK_LOW) with sync2 back at the old level, return to IDLE_LOW (IDLE_HIGH), zero cnt and produce no pulse.
REQ-016 SHALL, in CHECK_x with sync2 at the new level, increment cnt; when cnt==STABLE_CYCLES-1, move to IDLE_HIGH (IDLE_LOW) and zero cnt.
REQ-017 SHALL make btn_level registered: 1 in IDLE_HIGH and CHECK_LOW, 0 otherwise.
REQ-018 SHALL raise btn_level STABLE_CYCLES+3 rising edges after the first edge that samples btn_in=1, given clean input.
REQ-019 SHALL assert btn_press (btn_release) for exactly the one cycle in which btn_level first reads 1 (0); the pulses are mutually exclusive.
REQ-020 SHALL set press_pending on the cycle btn_press asserts and clear it on the clk edge that samples pending_clr=1.
REQ-021 SHALL let set win when btn_press and pending_clr coincide, leaving press_pending=1.
REQ-022 SHALL ensure glitches shorter than STABLE_CYCLES synced cycles never change btn_level or pulse any output.
REQ-023 SHALL never let cnt exceed STABLE_CYCLES-1 (no wrap).

Reset
REQ-024 SHALL, with reset=1, drive sync1=sync2=0, state IDLE_LOW, cnt=0, btn_level=0, btn_press=0, btn_release=0, press_pending=0 and press_count=0.
REQ-025 SHALL make reset mid-CHECK abort the check with no pulse; a held button is re-accepted via the normal path after reset deasserts.
REQ-026 SHALL give reset priority over pending_clr and all other inputs.

Configuration
REQ-027 SHALL, when BTN_PRESS_COUNT_EN is defined, include press_count, incrementing it on each btn_press and wrapping 255->0.
REQ-028 SHALL, when BTN_PRESS_COUNT_EN is undefined, omit the press_count port and its register entirely.

Structure
REQ-029 SHALL place the state enum (IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW) and the default STABLE_CYCLES constant in shared package btn_pkg.
REQ-030 SHALL instantiate one sub-module, sync_2ff, as the generic 1-bit two-flop synchronizer; the FSM, counters and flags are inline.

Verification (STABLE_CYCLES=4)
REQ-031 SHALL cover clean press: btn_in 0->1 held -> btn_level=1 at edge 7, btn_press high exactly one cycle, press_pending=1.
REQ-032 SHALL cover glitch rejection: btn_in high for 3 cycles, then low -> btn_level stays 0, no btn_press.
REQ-033 SHALL cover bounce: pattern 1,0,1,1,0 then steady 1 -> exactly one btn_press, 7 edges after the final 0->1.
REQ-034 SHALL cover release: held button released and held low -> btn_release one cycle, btn_level=0; press_pending unchanged.
REQ-035 SHALL cover set/clear collision: pending_clr=1 on the btn_press cycle -> press_pending=1; pending_clr next cycle -> 0.
REQ-036 SHALL cover reset mid-check: reset during CHECK_HIGH with button held -> outputs 0, no pulse; after release of reset, btn_press fires 7 edges later; with BTN_PRESS_COUNT_EN, 256 presses -> press_count=0.
